// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder slice.
// Digit type, controller state encoding and BCD correction constants.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } ctrl_state_t;

    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder cell.
// Combinational: a + b + cin with decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] raw;

    always_comb begin
        raw     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        cout    = raw > 5'(BCD_MAX);
        sum     = cout ? raw[3:0] + 4'(BCD_CORR) : raw[3:0];
        invalid = (a > 4'(BCD_MAX)) | (b > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial multi-digit BCD adder: one shared digit cell, ones digit first.
// Start/Done handshake; Sum and Error hold until the next accepted Start.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [4*DIGITS-1:0]     A,
    input  logic [4*DIGITS-1:0]     B,
    input  logic                    Cin,
    output logic                    Ready,
    output logic                    Busy,
    output logic                    Done,
    output logic [4*(DIGITS+1)-1:0] Sum,
    output logic                    Error
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;

    ctrl_state_t state, nextState;

    logic [IW-1:0] idx;
    logic [W-1:0]  aReg, bReg;
    logic          carry;
    logic          accept;
    logic          lastStep;
    bcd_digit_t    digit;
    logic          cout;
    logic          invalid;

    assign accept   = Start & Ready;
    assign lastStep = (state == ADD) && (idx == IW'(DIGITS - 1));

    // Operands shift right so the cell always sees the current digit at [3:0].
    bcd_digit_add uAdd (
        .a       (aReg[3:0]),
        .b       (bReg[3:0]),
        .cin     (carry),
        .sum     (digit),
        .cout    (cout),
        .invalid (invalid)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (Start) nextState = ADD;
            ADD:     if (lastStep) nextState = DONE;
            DONE:    nextState = Start ? ADD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state == ADD);
        Ready = ~Busy;
        Done  = (state == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            aReg  <= '0;
            bReg  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            Sum   <= '0;
            Error <= 1'b0;
        end else if (accept) begin
            aReg  <= A;
            bReg  <= B;
            carry <= Cin;
            idx   <= '0;
            Sum   <= '0;
            Error <= 1'b0;
        end else if (state == ADD) begin
            aReg  <= aReg >> 4;
            bReg  <= bReg >> 4;
            carry <= cout;
            idx   <= idx + 1'b1;
            Error <= Error | invalid;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) Sum[4*i +: 4] <= digit;
            end
            if (lastStep) Sum[W +: 4] <= {3'b000, cout};
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4).
// Scoreboard of model results, popped when Done pulses.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int SW     = 4 * (DIGITS + 1);

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          err;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Cin   = 1'b0;
    logic [W-1:0]  A     = '0;
    logic [W-1:0]  B     = '0;
    logic          Ready, Busy, Done, Error;
    logic [SW-1:0] Sum;

    int   nCmp      = 0;
    int   nErr      = 0;
    int   doneCount = 0;
    logic prevDone  = 1'b0;
    exp_t sbq[$];

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Ready (Ready),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Error (Error)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin);
        exp_t r;
        logic c;
        int   ad, bd, s;
        r = '0;
        c = cin;
        for (int k = 0; k < DIGITS; k++) begin
            ad = int'(a[4*k +: 4]);
            bd = int'(b[4*k +: 4]);
            s  = ad + bd + int'(c);
            if (s > 9) begin
                r.sum[4*k +: 4] = 4'((s + 6) % 16);
                c = 1'b1;
            end else begin
                r.sum[4*k +: 4] = 4'(s);
                c = 1'b0;
            end
            if (ad > 9 || bd > 9) r.err = 1'b1;
        end
        r.sum[4*DIGITS +: 4] = {3'b000, c};
        return r;
    endfunction

    function automatic logic [W-1:0] rndBcd();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    always @(negedge Clock) begin
        logic nb;
        logic nonEmpty;
        exp_t e;
        nb = ~Busy;
        check("readyNotBusy", Ready, nb);
        check("doneWithBusy", Done & Busy, 0);
        check("doneSingle", Done & prevDone, 0);
        prevDone <= Done;
        if (Done) begin
            doneCount++;
            nonEmpty = (sbq.size() != 0);
            check("doneExpected", nonEmpty, 1);
            if (nonEmpty) begin
                e = sbq.pop_front();
                check("sbSum", Sum, e.sum);
                check("sbErr", Error, e.err);
            end
        end
    end

    task automatic idle();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        A     = a;
        B     = b;
        Cin   = cin;
        Start = 1'b1;
        sbq.push_back(model(a, b, cin));
    endtask

    task automatic waitDone(input string tag, input bit inject);
        int lat;
        lat = 0;
        do begin
            @(posedge Clock);
            #1;
            Start = 1'b0;
            lat++;
            if (inject && lat == 2) begin
                A     = 16'h8888;
                B     = 16'h8888;
                Cin   = 1'b1;
                Start = 1'b1;
            end
        end while (!Done && lat < 40);
        check(tag, lat, DIGITS + 1);
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge Clock);
        #1;
        check("rstReady", Ready, 1);
        check("rstBusy", Busy, 0);
        check("rstDone", Done, 0);
        check("rstSum", Sum, 0);
        check("rstError", Error, 0);
        Reset = 1'b0;

        idle();
        issue(16'h1234, 16'h5678, 1'b0);
        waitDone("lat1234", 1'b0);
        check("t1Sum", Sum, 20'h06912);
        check("t1Err", Error, 0);

        idle();
        issue(16'h9999, 16'h0001, 1'b0);
        waitDone("lat9999p1", 1'b0);
        check("t2Sum", Sum, 20'h10000);

        idle();
        issue(16'h0000, 16'h0000, 1'b1);
        waitDone("latCin", 1'b0);
        check("t3aSum", Sum, 20'h00001);
        idle();
        issue(16'h9999, 16'h9999, 1'b1);
        waitDone("latMax", 1'b0);
        check("t3bSum", Sum, 20'h19999);

        repeat (3) idle();
        check("holdSum", Sum, 20'h19999);
        check("holdReady", Ready, 1);

        idle();
        d0 = doneCount;
        issue(16'h1111, 16'h2222, 1'b0);
        waitDone("latMidStart", 1'b1);
        check("t4Sum", Sum, 20'h03333);
        repeat (8) idle();
        check("t4OneDone", doneCount - d0, 1);

        idle();
        A     = 16'h4321;
        B     = 16'h1111;
        Cin   = 1'b0;
        Start = 1'b1;
        idle();
        Start = 1'b0;
        idle();
        check("t5InAdd", Busy, 1);
        Reset = 1'b1;
        idle();
        check("t5Ready", Ready, 1);
        check("t5Busy", Busy, 0);
        check("t5Sum", Sum, 0);
        check("t5Err", Error, 0);
        Reset = 1'b0;
        d0 = doneCount;
        repeat (8) idle();
        check("t5NoDone", doneCount - d0, 0);
        issue(16'h4321, 16'h1111, 1'b0);
        waitDone("latAfterRst", 1'b0);
        check("t5bSum", Sum, 20'h05432);

        idle();
        issue(16'h00A0, 16'h0001, 1'b0);
        waitDone("latInvalid", 1'b0);
        check("t6Err", Error, 1);
        idle();
        issue(16'h0005, 16'h0004, 1'b0);
        idle();
        Start = 1'b0;
        check("t6ErrClr", Error, 0);
        check("t6SumClr", Sum, 0);
        repeat (4) idle();
        check("t6Done", Done, 1);
        check("t6bErr", Error, 0);
        check("t6bSum", Sum, 20'h00009);

        idle();
        issue(rndBcd(), rndBcd(), 1'($urandom_range(0, 1)));
        waitDone("latB2B0", 1'b0);
        for (int n = 1; n < 5; n++) begin
            issue(rndBcd(), rndBcd(), 1'($urandom_range(0, 1)));
            waitDone("latB2B", 1'b0);
        end

        repeat (3) idle();
        check("sbDrained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
